tage_pred_info_queue: RTL and testbench
=======================================

Name: tage_pred_info_queue

Overview:
- In-order FIFO between the TAGE predictor output and the commit-side TAGE update port.
- Captures the prediction metadata for every predicted branch: prediction info, predicted direction and branch PC.
- Holds each entry until the branch commits, then presents it as the update-side prediction info for that branch.
- Flushes all speculative entries on pipeline recovery.

Parameters:
- DEPTH, 16, number of in-flight branch entries; power of two, ≥ 2.
- INFO_W, 64, width of one packed TAGE prediction-info record.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pause  in  1  frontend stall; blocks enqueue
- recover  in  1  pipeline redirect; flushes the queue
- enq_valid  in  1  predictor has a branch prediction this cycle
- enq_pc  in  32  branch PC of the prediction
- enq_taken  in  1  predicted direction
- enq_info  in  INFO_W  prediction-info record
- enq_ready  out  1  queue can accept (not full)
- commit_valid  in  1  oldest branch commits this cycle
- committed_pc  in  32  PC of the committing branch
- deq_valid  out  1  head entry present (not empty)
- deq_pc  out  32  head PC
- deq_taken  out  1  head predicted direction
- deq_info  out  INFO_W  head info; drives the committed prediction-info input of the update port
- count  out  PTR_W+1  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Storage is a circular buffer with wr_ptr, rd_ptr and a count register. Pointers wrap from DEPTH-1 to 0.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0. Consequently empty=1, full=0, enq_ready=1, deq_valid=0. Entry storage is not reset; deq_* outputs are don't-care while empty.
- Enqueue fires when enq_valid & enq_ready & !pause & !recover. It writes {enq_pc, enq_taken, enq_info} at wr_ptr; wr_ptr+1.
- enq_ready = !full. It does not depend on enq_valid, pause or recover.
- Dequeue fires when commit_valid & deq_valid. rd_ptr+1.
- deq_* are combinational reads of entry[rd_ptr], so they are valid in the same cycle as commit_valid (zero-latency head view).
- A written entry is visible at the head no earlier than the cycle after the write. There is no enqueue-to-dequeue bypass.
- Simultaneous enqueue and dequeue: count unchanged. When full, no enqueue occurs (enq_ready=0), even if a dequeue happens in the same cycle.
- commit_valid while empty: ignored; no state change.
- recover=1: the next state is wr_ptr=rd_ptr=count=0, which discards every entry. Any enqueue that cycle is suppressed.
- recover and commit_valid in the same cycle: the head is still presented combinationally that cycle so the update port consumes it; the queue is then empty next cycle.
- pause only blocks enqueue; dequeue and recover proceed.
- count: +1 on enqueue only, -1 on dequeue only, unchanged otherwise. It never exceeds DEPTH or goes below 0.
- No state machine beyond the pointer/count datapath. The implementation drives full and empty from count, not from pointer comparison.

Optional Feature:
- Macro: TAGE_PIQ_PC_CHECK_EN.
- With the macro defined:
  - A dequeue whose committed_pc != deq_pc sets a sticky pc_mismatch output register (extra port, 1 bit).
  - commit_valid while empty sets a sticky underflow output register (extra port, 1 bit).
  - Both registers reset to 0 only by rst; recover does not clear them.
  - The dequeue still proceeds normally.
- Without the macro: committed_pc is unused, neither extra port exists, and no comparison logic is built.

Test Plan:
- Reset, then enqueue PCs 0x100, 0x104, 0x108 on three consecutive cycles (pause=0) → count=3. deq_pc=0x100 from the cycle after the first write. Three commits return 0x100, 0x104, 0x108 in order, then empty=1.
- Enqueue 16 entries with DEPTH=16 → full=1, enq_ready=0. A 17th enq_valid is dropped. One commit → count=15, enq_ready=1. Refill and drain 32 more entries → correct order across pointer wrap.
- Queue at count=5; enqueue and commit in the same cycle → count stays 5; head advances by one.
- Queue at count=4; assert recover together with commit_valid and enq_valid → the head is visible that cycle; next cycle count=0, empty=1; the new entry is absent.
- pause=1 with enq_valid=1 for 3 cycles while committing 2 → count drops by 2 and no entries are added.
- TAGE_PIQ_PC_CHECK_EN defined: head 0x200, commit with committed_pc=0x204 → pc_mismatch=1 and stays 1 after recover. commit_valid when empty → underflow=1.

Source files
------------

// File: rtl/tage_pred_info_queue.sv
// -----------------------------------------------------------------------------
// tage_pred_info_queue
//
// In-order FIFO between the TAGE predictor output and the commit-side TAGE
// update port. Every predicted branch deposits its prediction metadata
// (info record, predicted direction, branch PC). The entry waits until that
// branch commits, at which point the head is presented to the update port.
// A pipeline recovery discards every speculative entry.
//
// Optional build macro: TAGE_PIQ_PC_CHECK_EN
//   Adds sticky pc_mismatch / underflow debug flags (cleared only by rst).
//   Without it, committed_pc is ignored and no compare logic exists.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pause             frontend stall, blocks enqueue only
//   recover           pipeline redirect, empties the queue next cycle
//   enq_valid/pc/taken/info   prediction to enqueue
//   enq_ready         queue not full (independent of enq_valid/pause/recover)
//   commit_valid      oldest branch commits this cycle
//   committed_pc      PC of the committing branch (checked only with macro)
//   deq_valid/pc/taken/info   combinational view of the head entry
//   count             occupancy, 0..DEPTH
//   full, empty       derived from count
//   pc_mismatch       (macro) sticky: committed_pc differed from head PC
//   underflow         (macro) sticky: commit_valid seen while empty
// -----------------------------------------------------------------------------
module tage_pred_info_queue #(
  parameter int  DEPTH  = 16,
  parameter int  INFO_W = 64,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              recover,
  input  logic              enq_valid,
  input  logic [31:0]       enq_pc,
  input  logic              enq_taken,
  input  logic [INFO_W-1:0] enq_info,
  output logic              enq_ready,
  input  logic              commit_valid,
  input  logic [31:0]       committed_pc,
  output logic              deq_valid,
  output logic [31:0]       deq_pc,
  output logic              deq_taken,
  output logic [INFO_W-1:0] deq_info,
  output logic [PTR_W:0]    count,
`ifdef TAGE_PIQ_PC_CHECK_EN
  output logic              pc_mismatch,
  output logic              underflow,
`endif
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count_q;

  logic [31:0]       pc_mem    [DEPTH];
  logic              taken_mem [DEPTH];
  logic [INFO_W-1:0] info_mem  [DEPTH];

  logic full_w;
  logic empty_w;
  logic enq_fire;
  logic deq_fire;

  assign full_w  = (count_q == COUNT_FULL);
  assign empty_w = (count_q == '0);

  // A full queue never accepts, even if the head leaves this same cycle;
  // this keeps enq_ready a pure function of registered state.
  assign enq_fire = enq_valid & ~full_w & ~pause & ~recover;
  assign deq_fire = commit_valid & ~empty_w;

  assign enq_ready = ~full_w;
  assign deq_valid = ~empty_w;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;

  // Head view is a plain read of registered storage, so an entry written
  // this cycle cannot appear at the head until the next cycle.
  assign deq_pc    = pc_mem[rd_ptr];
  assign deq_taken = taken_mem[rd_ptr];
  assign deq_info  = info_mem[rd_ptr];

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
  // natural binary rollover implements the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (recover) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[wr_ptr]    <= enq_pc;
      taken_mem[wr_ptr] <= enq_taken;
      info_mem[wr_ptr]  <= enq_info;
    end
  end

`ifdef TAGE_PIQ_PC_CHECK_EN
  // Sticky debug flags survive recover so a post-mortem can still see them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_mismatch <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (deq_fire && (committed_pc != pc_mem[rd_ptr])) begin
        pc_mismatch <= 1'b1;
      end
      if (commit_valid && empty_w) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  logic unused_committed_pc;
  assign unused_committed_pc = ^committed_pc;
`endif

endmodule

// File: tb/tb_tage_pred_info_queue.sv
module tb_tage_pred_info_queue;

  localparam int DEPTH  = 16;
  localparam int INFO_W = 64;

  logic              clk;
  logic              rst;
  logic              pause;
  logic              recover;
  logic              enq_valid;
  logic [31:0]       enq_pc;
  logic              enq_taken;
  logic [INFO_W-1:0] enq_info;
  logic              enq_ready;
  logic              commit_valid;
  logic [31:0]       committed_pc;
  logic              deq_valid;
  logic [31:0]       deq_pc;
  logic              deq_taken;
  logic [INFO_W-1:0] deq_info;
  logic [4:0]        count;
  logic              full;
  logic              empty;
`ifdef TAGE_PIQ_PC_CHECK_EN
  logic              pc_mismatch;
  logic              underflow;
`endif

  tage_pred_info_queue #(.DEPTH(DEPTH), .INFO_W(INFO_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pause        (pause),
    .recover      (recover),
    .enq_valid    (enq_valid),
    .enq_pc       (enq_pc),
    .enq_taken    (enq_taken),
    .enq_info     (enq_info),
    .enq_ready    (enq_ready),
    .commit_valid (commit_valid),
    .committed_pc (committed_pc),
    .deq_valid    (deq_valid),
    .deq_pc       (deq_pc),
    .deq_taken    (deq_taken),
    .deq_info     (deq_info),
    .count        (count),
`ifdef TAGE_PIQ_PC_CHECK_EN
    .pc_mismatch  (pc_mismatch),
    .underflow    (underflow),
`endif
    .full         (full),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       pc;
    logic              tk;
    logic [INFO_W-1:0] info;
  } ent_t;

  ent_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_count = 0;
  logic bad_pc = 1'b0;

  function automatic logic [INFO_W-1:0] mk_info(input logic [31:0] pc);
    return {~pc, pc ^ 32'h5A5A_5A5A};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input int c);
    chk({tag, "_count"},     64'(count),     64'(c));
    chk({tag, "_empty"},     64'(empty),     64'(c == 0));
    chk({tag, "_full"},      64'(full),      64'(c == DEPTH));
    chk({tag, "_enq_ready"}, 64'(enq_ready), 64'(c != DEPTH));
    chk({tag, "_deq_valid"}, 64'(deq_valid), 64'(c != 0));
  endtask

  // One clock of stimulus; the expected-data queue is updated at the edge.
  task automatic step(input logic en, input logic [31:0] pc, input logic cm,
                      input logic ps, input logic rc);
    logic enq_ok;
    logic deq_ok;
    ent_t e;
    enq_valid    = en;
    enq_pc       = pc;
    enq_taken    = pc[2];
    enq_info     = mk_info(pc);
    commit_valid = cm;
    pause        = ps;
    recover      = rc;
    committed_pc = (sb_q.size() > 0) ? (sb_q[0].pc + (bad_pc ? 32'd4 : 32'd0)) : 32'h0;
    @(posedge clk);
    enq_ok = en && !ps && !rc && (exp_count < DEPTH);
    deq_ok = cm && (exp_count > 0);
    if (rc) begin
      exp_count = 0;
      sb_q.delete();
    end else begin
      if (enq_ok) begin
        e.pc = pc; e.tk = pc[2]; e.info = mk_info(pc);
        sb_q.push_back(e);
      end
      exp_count = exp_count + int'(enq_ok) - int'(deq_ok);
    end
    #1;
    enq_valid = 1'b0; commit_valid = 1'b0; pause = 1'b0; recover = 1'b0;
  endtask

  task automatic enq(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmt();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: whenever the update port consumes the head, compare it with
  // the oldest expected entry.
  ent_t mon_e;
  always @(negedge clk) begin
    if (!rst && commit_valid) begin
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("mon_deq_valid", 64'(deq_valid), 64'd1);
        chk("mon_deq_pc",    64'(deq_pc),    64'(mon_e.pc));
        chk("mon_deq_taken", 64'(deq_taken), 64'(mon_e.tk));
        chk("mon_deq_info",  deq_info,       mon_e.info);
      end else begin
        chk("mon_empty_deq_valid", 64'(deq_valid), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pause = 1'b0; recover = 1'b0; enq_valid = 1'b0;
    enq_pc = '0; enq_taken = 1'b0; enq_info = '0;
    commit_valid = 1'b0; committed_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("in_reset", 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_state("reset", 0);

    // Basic order.
    enq(32'h100);
    chk("head_after_first", 64'(deq_pc), 64'h100);
    chk("valid_after_first", 64'(deq_valid), 64'd1);
    enq(32'h104);
    enq(32'h108);
    chk_state("fill3", 3);
    repeat (3) cmt();
    chk_state("drain3", 0);

    // Full boundary and wrap.
    for (int i = 0; i < 16; i++) enq(32'h1000 + 32'(4 * i));
    chk_state("full16", 16);
    enq(32'hDEAD);
    chk_state("drop17", 16);
    cmt();
    chk_state("after_one_commit", 15);
    enq(32'h2000);
    chk_state("refull", 16);
    step(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
    chk_state("full_enq_and_commit", 15);
    for (int i = 0; i < 32; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    chk_state("wrap_steady", 15);
    repeat (15) cmt();
    chk_state("wrap_drained", 0);

    // Simultaneous enqueue and commit at count 5.
    for (int i = 0; i < 5; i++) enq(32'h300 + 32'(4 * i));
    chk_state("five", 5);
    step(1'b1, 32'h314, 1'b1, 1'b0, 1'b0);
    chk_state("five_simul", 5);
    chk("head_advanced", 64'(deq_pc), 64'h304);
    repeat (5) cmt();
    chk_state("five_drained", 0);

    // Recover with commit and enqueue in the same cycle.
    enq(32'h400); enq(32'h404); enq(32'h408); enq(32'h40C);
    chk_state("four", 4);
    step(1'b1, 32'h4F0, 1'b1, 1'b0, 1'b1);
    chk_state("recovered", 0);
    enq(32'h500);
    chk("head_after_recover", 64'(deq_pc), 64'h500);
    chk_state("post_recover_one", 1);
    cmt();

    // Pause blocks enqueue, commits proceed.
    enq(32'h600); enq(32'h604); enq(32'h608);
    step(1'b1, 32'h6A0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h6A4, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h6A8, 1'b1, 1'b1, 1'b0);
    chk_state("paused", 1);
    chk("paused_head", 64'(deq_pc), 64'h608);
    cmt();
    chk_state("paused_drained", 0);

`ifdef TAGE_PIQ_PC_CHECK_EN
    chk("no_mismatch_yet", 64'(pc_mismatch), 64'd0);
    chk("no_underflow_yet", 64'(underflow), 64'd0);
    enq(32'h200);
    bad_pc = 1'b1;
    cmt();
    bad_pc = 1'b0;
    chk("pc_mismatch_set", 64'(pc_mismatch), 64'd1);
    chk_state("mismatch_deq", 0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("pc_mismatch_sticky", 64'(pc_mismatch), 64'd1);
    cmt();
    chk("underflow_set", 64'(underflow), 64'd1);
    chk_state("underflow_state", 0);
`endif

    @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
